ldpc_msg_ram: RTL

LDPC_MSG_RAM -- requirements
Module: ldpc_msg_ram

---
 rtl/ldpc_ram_pkg.sv | 10 +
 rtl/ldpc_msg_ram_core.sv | 31 +++
 rtl/ldpc_msg_ram.sv | 119 +++++++++++
 3 files changed

// File: rtl/ldpc_ram_pkg.sv
// Shared defaults and clear-FSM state encoding for the LDPC message RAM.
package ldpc_ram_pkg;

  localparam int unsigned DATA_W_DEF = 7;
  localparam int unsigned ADDR_W_DEF = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/ldpc_msg_ram_core.sv
// Simple dual-port message array: synchronous write, registered read (old data on collision).
module ldpc_msg_ram_core
  import ldpc_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ldpc_msg_ram.sv
// LDPC message RAM: registered write stage, clear-sweep FSM, optional write-to-read
// forwarding when LDPC_MSG_RAM_FWD_EN is defined.
module ldpc_msg_ram
  import ldpc_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  logic [0:0]        state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              done_nxt;
  logic              clr_wr;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_din_q;
  logic [DATA_W-1:0] core_rd;

  // Clear FSM: state/counter registers plus registered busy/done flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_busy <= (state_nxt == ST_CLEAR);
      clr_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    clr_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        clr_wr  = 1'b1;
        cnt_nxt = cnt + (ADDR_W+1)'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write stage; the sweep owns it while clearing and external writes are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_din_q  <= '0;
    end else begin
      wr_en_q   <= clr_wr | wren;
      wr_addr_q <= clr_wr ? cnt[ADDR_W-1:0] : wr_addr;
      wr_din_q  <= clr_wr ? '0 : din;
    end
  end

  ldpc_msg_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_din_q),
    .rd_addr (rd_addr),
    .rd_data (core_rd)
  );

`ifdef LDPC_MSG_RAM_FWD_EN
  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;

  // Bypass the pending write into the read register when it hits the read address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= wr_en_q && (wr_addr_q == rd_addr);
      fwd_data_q <= wr_din_q;
    end
  end

  assign dout = fwd_hit_q ? fwd_data_q : core_rd;
`else
  assign dout = core_rd;
`endif

endmodule
